// File: rtl/mult_err_monitor_pkg.sv
// Shared types and helpers for the multiplier error monitor.
// Imported by the top, the stats accumulator and the bench.
package mult_err_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } mon_state_e;

  // Widest operand absdiff accepts; callers cast in and out.
  localparam int AD_W = 65;

  function automatic logic [AD_W-1:0] absdiff(
    input logic [AD_W-1:0] a,
    input logic [AD_W-1:0] b
  );
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/mult_err_monitor_if.sv
// Operand stream into the error monitor.
// A pair transfers on a cycle where s_valid and s_ready are both high.
interface mult_err_monitor_if #(
  parameter int WIDTH = 8
);

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_in1;
  logic [WIDTH-1:0] s_in2;

  modport master (
    output s_valid,
    output s_in1,
    output s_in2,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_in1,
    input  s_in2,
    output s_ready
  );

endinterface

// File: rtl/mult_err_monitor_stats.sv
// Stage 3 of the monitor: sample/error counters,
// saturating error sum and max error tracker.
module err_stats_acc #(
  parameter int CNT_W = 16,
  parameter int ACC_W = 32,
  parameter int EW    = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             upd,
  input  logic [EW-1:0]    e,
  output logic [CNT_W-1:0] samp_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] err_sum,
  output logic [EW-1:0]    err_max,
  output logic             sum_sat
);

  localparam int SW = ((ACC_W > EW) ? ACC_W : EW) + 1;

  logic [CNT_W-1:0] samp_q;
  logic [CNT_W-1:0] errc_q;
  logic [ACC_W-1:0] sum_q;
  logic [EW-1:0]    max_q;
  logic             sat_q;
  logic [SW-1:0]    sum_w;
  logic             clamp;

  // Add in a width that can hold either operand plus a carry.
  assign sum_w = SW'(sum_q) + SW'(e);
  assign clamp = sum_w > SW'({ACC_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      samp_q <= '0;
      errc_q <= '0;
      sum_q  <= '0;
      max_q  <= '0;
      sat_q  <= 1'b0;
    end else if (upd) begin
      samp_q <= samp_q + CNT_W'(1);
      if (e != '0)
        errc_q <= errc_q + CNT_W'(1);
      if (e > max_q)
        max_q <= e;
      if (clamp) begin
        sum_q <= '1;
        sat_q <= 1'b1;
      end else begin
        sum_q <= sum_w[ACC_W-1:0];
      end
    end
  end

  assign samp_cnt = samp_q;
  assign err_cnt  = errc_q;
  assign err_sum  = sum_q;
  assign err_max  = max_q;
  assign sum_sat  = sat_q;

endmodule

// File: rtl/mult_err_monitor.sv
// Characterisation stage for approximate multipliers: feeds operands,
// compares {mul_ovf, mul_out} with the exact product, collects stats.
module mult_err_monitor
  import mult_err_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  mult_err_monitor_if.slave  s,
  output logic [WIDTH-1:0]   mul_in1,
  output logic [WIDTH-1:0]   mul_in2,
  input  logic [2*WIDTH-1:0] mul_out,
  input  logic               mul_ovf,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   samp_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [ACC_W-1:0]   err_sum,
  output logic [2*WIDTH:0]   err_max,
  output logic               sum_sat
);

  localparam int PW = 2*WIDTH+1;

  mon_state_e       state_q;
  logic [CNT_W-1:0] nsamp_q;
  logic [CNT_W-1:0] acc_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] in1_q;
  logic [WIDTH-1:0] in2_q;
  logic             v1_q;
  logic             v2_q;
  logic [PW-1:0]    approx_q;
  logic [PW-1:0]    exact_q;

  logic          fire;
  logic          last;
  logic          start_ok;
  logic [PW-1:0] e;

  assign s.s_ready = (state_q == RUN) && (acc_q < nsamp_q);
  assign fire      = s.s_valid && s.s_ready;
  assign last      = fire && ((acc_q + CNT_W'(1)) == nsamp_q);
  assign start_ok  = start &&
                     ((state_q == IDLE) || (state_q == DONE));
  assign e = PW'(absdiff(AD_W'(approx_q), AD_W'(exact_q)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      nsamp_q <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            nsamp_q <= num_samples;
            acc_q   <= '0;
            busy_q  <= (num_samples != '0);
            done_q  <= (num_samples == '0);
            state_q <= (num_samples == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (fire)
            acc_q <= acc_q + CNT_W'(1);
          if (last)
            state_q <= DRAIN;
        end
        DRAIN: begin
          if (!v1_q && !v2_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Operand and capture registers: one sample per stage per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in1_q    <= '0;
      in2_q    <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      approx_q <= '0;
      exact_q  <= '0;
    end else begin
      v1_q <= fire;
      v2_q <= v1_q;
      if (fire) begin
        in1_q <= s.s_in1;
        in2_q <= s.s_in2;
      end
      if (v1_q) begin
        approx_q <= {mul_ovf, mul_out};
        exact_q  <= PW'(in1_q) * PW'(in2_q);
      end
    end
  end

  err_stats_acc #(
    .CNT_W (CNT_W),
    .ACC_W (ACC_W),
    .EW    (PW)
  ) u_stats (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_ok),
    .upd      (v2_q),
    .e        (e),
    .samp_cnt (samp_cnt),
    .err_cnt  (err_cnt),
    .err_sum  (err_sum),
    .err_max  (err_max),
    .sum_sat  (sum_sat)
  );

  assign mul_in1 = in1_q;
  assign mul_in2 = in2_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mult_err_monitor.sv
// Bench for mult_err_monitor: two instances (32-bit and 4-bit sum)
// driven in lockstep against a sample-list reference model.
module tb_mult_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  int          mode = 0;

  always #5 clk = ~clk;

  mult_err_monitor_if #(.WIDTH(8)) sif ();
  mult_err_monitor_if #(.WIDTH(8)) sif4 ();

  assign sif4.s_valid = sif.s_valid;
  assign sif4.s_in1   = sif.s_in1;
  assign sif4.s_in2   = sif.s_in2;

  logic [7:0]  m_in1, m_in2, q_in1, q_in2;
  logic [15:0] m_out, q_out;
  logic        m_ovf, q_ovf;
  logic        busy, done, sum_sat;
  logic        busy4, done4, sum_sat4;
  logic [15:0] samp_cnt, err_cnt, samp_cnt4, err_cnt4;
  logic [31:0] err_sum;
  logic [3:0]  err_sum4;
  logic [16:0] err_max, err_max4;

  // Behavioural approximate multiplier, error shape chosen by md.
  function automatic logic [16:0] approx_of(
    input int md, input logic [7:0] a, input logic [7:0] b);
    logic [16:0] ex;
    ex = 17'(a) * 17'(b);
    case (md)
      1: return (ex != 0) ? ex - 17'd1 : ex;
      2: return ex + 17'd5;
      3: return ex ^ {a[0] & b[0], 12'd0, a[3:0] ^ b[7:4]};
      default: return ex;
    endcase
  endfunction

  assign {m_ovf, m_out} = approx_of(mode, m_in1, m_in2);
  assign {q_ovf, q_out} = approx_of(mode, q_in1, q_in2);

  mult_err_monitor #(.WIDTH(8), .CNT_W(16), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_samples(num_samples), .s(sif.slave),
    .mul_in1(m_in1), .mul_in2(m_in2),
    .mul_out(m_out), .mul_ovf(m_ovf),
    .busy(busy), .done(done),
    .samp_cnt(samp_cnt), .err_cnt(err_cnt),
    .err_sum(err_sum), .err_max(err_max),
    .sum_sat(sum_sat)
  );

  mult_err_monitor #(.WIDTH(8), .CNT_W(16), .ACC_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_samples(num_samples), .s(sif4.slave),
    .mul_in1(q_in1), .mul_in2(q_in2),
    .mul_out(q_out), .mul_ovf(q_ovf),
    .busy(busy4), .done(done4),
    .samp_cnt(samp_cnt4), .err_cnt(err_cnt4),
    .err_sum(err_sum4), .err_max(err_max4),
    .sum_sat(sum_sat4)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] pa[$], pb[$], fa[$], fb[$];
  logic [7:0] last_a = 0, last_b = 0;

  task automatic drive_run(input int n, input int m, input int pct,
                           input int hold, input bit poke);
    int acc, last_t, fi, cyc, ex, ap, e, sc, ec, mx;
    longint tot, s32, s4;
    bit exp_r, exp_d, v;
    logic [7:0] a, b;
    mode = m;
    pa.delete();
    pb.delete();
    @(negedge clk);
    start = 1'b1;
    num_samples = n[15:0];
    sif.s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    acc = 0; last_t = -1; fi = 0;
    for (cyc = 0; cyc < 400; cyc++) begin
      exp_r = (acc < n);
      exp_d = (n == 0) || (last_t >= 0 && cyc >= last_t + 4);
      n_chk++;
      if ({sif.s_ready, sif4.s_ready} !== {exp_r, exp_r})
        $display("FAIL ready cyc=%0d got=%b%b exp=%b", cyc,
                 sif.s_ready, sif4.s_ready, exp_r);
      else n_pass++;
      n_chk++;
      if ({done, busy, done4, busy4} !== {exp_d, !exp_d, exp_d, !exp_d})
        $display("FAIL done_busy cyc=%0d got=%b%b%b%b exp_done=%b",
                 cyc, done, busy, done4, busy4, exp_d);
      else n_pass++;
      n_chk++;
      if ({m_in1, m_in2} !== {last_a, last_b})
        $display("FAIL mul_in cyc=%0d got=%h,%h exp=%h,%h",
                 cyc, m_in1, m_in2, last_a, last_b);
      else n_pass++;
      if (acc == n && cyc >= hold && cyc >= last_t + 5) break;
      v = (cyc < hold) || (acc < n && $urandom_range(99) < pct);
      if (fi < fa.size()) begin
        a = fa[fi]; b = fb[fi];
      end else begin
        a = 8'($urandom); b = 8'($urandom);
      end
      start = poke && (cyc == 1 || (last_t >= 0 && cyc == last_t + 2));
      num_samples = start ? 16'd1 : n[15:0];
      sif.s_valid = v;
      sif.s_in1 = a;
      sif.s_in2 = b;
      if (v && exp_r) begin
        pa.push_back(a); pb.push_back(b);
        acc++; fi++;
        last_a = a; last_b = b;
        if (acc == n) last_t = cyc;
      end
      @(negedge clk);
    end
    start = 1'b0;
    sif.s_valid = 1'b0;
    n_chk++;
    if (cyc >= 400)
      $display("FAIL run_timeout got=%0d cycles exp=<400", cyc);
    else n_pass++;
    sc = 0; ec = 0; mx = 0; tot = 0;
    foreach (pa[i]) begin
      ex = int'(pa[i]) * int'(pb[i]);
      ap = int'(approx_of(m, pa[i], pb[i]));
      e = (ap > ex) ? ap - ex : ex - ap;
      sc++;
      if (e != 0) ec++;
      if (e > mx) mx = e;
      tot += e;
    end
    s32 = (tot > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : tot;
    s4 = (tot > 15) ? 15 : tot;
    n_chk++;
    if ({samp_cnt, err_cnt, samp_cnt4, err_cnt4} !==
        {16'(sc), 16'(ec), 16'(sc), 16'(ec)})
      $display("FAIL counts got=%0d,%0d/%0d,%0d exp=%0d,%0d",
               samp_cnt, err_cnt, samp_cnt4, err_cnt4, sc, ec);
    else n_pass++;
    n_chk++;
    if ({err_max, err_max4} !== {17'(mx), 17'(mx)})
      $display("FAIL err_max got=%0d/%0d exp=%0d",
               err_max, err_max4, mx);
    else n_pass++;
    n_chk++;
    if ({err_sum, sum_sat} !== {32'(s32), tot > 64'hFFFF_FFFF})
      $display("FAIL err_sum32 got=%0d sat=%b exp=%0d", err_sum,
               sum_sat, s32);
    else n_pass++;
    n_chk++;
    if ({err_sum4, sum_sat4} !== {4'(s4), tot > 15})
      $display("FAIL err_sum4 got=%0d sat=%b exp=%0d sat=%b",
               err_sum4, sum_sat4, s4, tot > 15);
    else n_pass++;
    fa.delete();
    fb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_in1 = 8'h5a;
    sif.s_in2 = 8'ha5;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, done, samp_cnt, err_cnt, err_sum, err_max, sum_sat,
         m_in1, m_in2, sif.s_ready, busy4, done4, err_sum4} !== '0)
      $display("FAIL reset_state got busy=%b done=%b samp=%0d sum=%0d in=%h,%h rdy=%b exp=all 0",
               busy, done, samp_cnt, err_sum, m_in1, m_in2,
               sif.s_ready);
    else n_pass++;
    rst_n = 1'b1;
    last_a = 0;
    last_b = 0;
    @(negedge clk);
  endtask

  task automatic test_exact();
    fa = '{8'd15, 8'd255, 8'd0, 8'd1};
    fb = '{8'd15, 8'd255, 8'd7, 8'd1};
    drive_run(4, 0, 100, 0, 1'b0);
    n_chk++;
    if ({samp_cnt, err_cnt, err_sum, err_max, done} !==
        {16'd4, 16'd0, 32'd0, 17'd0, 1'b1})
      $display("FAIL exact got samp=%0d errc=%0d sum=%0d max=%0d done=%b exp=4,0,0,0,1",
               samp_cnt, err_cnt, err_sum, err_max, done);
    else n_pass++;
  endtask

  task automatic test_minus_one();
    fa = '{8'd15, 8'd0, 8'd3};
    fb = '{8'd15, 8'd9, 8'd3};
    drive_run(3, 1, 100, 0, 1'b0);
    n_chk++;
    if ({err_cnt, err_sum, err_max} !== {16'd2, 32'd2, 17'd1})
      $display("FAIL minus_one got errc=%0d sum=%0d max=%0d exp=2,2,1",
               err_cnt, err_sum, err_max);
    else n_pass++;
  endtask

  task automatic test_zero_samples();
    drive_run(0, 2, 100, 3, 1'b0);
    n_chk++;
    if ({samp_cnt, err_sum, err_max, done} !== {16'd0, 32'd0, 17'd0, 1'b1})
      $display("FAIL zero_samples got samp=%0d sum=%0d done=%b exp=0,0,1",
               samp_cnt, err_sum, done);
    else n_pass++;
  endtask

  task automatic test_hold_valid();
    drive_run(3, 3, 100, 6, 1'b0);
    n_chk++;
    if (samp_cnt !== 16'd3)
      $display("FAIL hold_valid got samp=%0d exp=3", samp_cnt);
    else n_pass++;
  endtask

  task automatic test_saturate();
    drive_run(4, 2, 100, 0, 1'b0);
    n_chk++;
    if ({err_sum4, sum_sat4, samp_cnt4, err_sum, sum_sat} !==
        {4'd15, 1'b1, 16'd4, 32'd20, 1'b0})
      $display("FAIL saturate got sum4=%0d sat4=%b samp4=%0d sum=%0d sat=%b exp=15,1,4,20,0",
               err_sum4, sum_sat4, samp_cnt4, err_sum, sum_sat);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    num_samples = 16'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      sif.s_valid = 1'b1;
      sif.s_in1 = 8'($urandom);
      sif.s_in2 = 8'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({busy, done, samp_cnt, err_cnt, err_sum, err_max, sum_sat,
         m_in1, m_in2, sif.s_ready, busy4, done4, err_sum4} !== '0)
      $display("FAIL mid_reset got busy=%b done=%b samp=%0d sum=%0d in=%h,%h rdy=%b exp=all 0",
               busy, done, samp_cnt, err_sum, m_in1, m_in2,
               sif.s_ready);
    else n_pass++;
    rst_n = 1'b1;
    sif.s_valid = 1'b0;
    last_a = 0;
    last_b = 0;
    repeat (4) @(negedge clk);
    n_chk++;
    if ({busy, done, samp_cnt, sif.s_ready} !== '0)
      $display("FAIL mid_reset_idle got busy=%b done=%b samp=%0d exp=0,0,0",
               busy, done, samp_cnt);
    else n_pass++;
    drive_run(5, 1, 100, 0, 1'b0);
    n_chk++;
    if ({samp_cnt, done} !== {16'd5, 1'b1})
      $display("FAIL after_reset got samp=%0d done=%b exp=5,1",
               samp_cnt, done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive_run(7, 3, 100, 0, 1'b1);
    drive_run(2, 1, 100, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++)
      drive_run(int'($urandom_range(40, 1)), (r % 2) ? 1 : 3,
                int'($urandom_range(100, 30)), 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_exact();
    test_minus_one();
    test_zero_samples();
    test_hold_valid();
    test_saturate();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
